// File: rtl/hbridge_pkg.sv
// hbridge_pkg - phase encoding and output decode helpers for the H-bridge pulse sequencer.
// Revision: 1.0
`default_nettype none

package hbridge_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_PEND  = 3'd1,
    PH_FWD   = 3'd2,
    PH_DEAD  = 3'd3,
    PH_REV   = 3'd4,
    PH_BRAKE = 3'd5
  } phase_e;

  // Driver pin levels are a pure function of the phase being entered.
  function automatic logic phase_drives_a(input phase_e ph);
    return (ph == PH_FWD) || (ph == PH_BRAKE);
  endfunction

  function automatic logic phase_drives_b(input phase_e ph);
    return (ph == PH_REV) || (ph == PH_BRAKE);
  endfunction

  function automatic logic phase_is_busy(input phase_e ph);
    return ph != PH_IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hbridge_channel.sv
// hbridge_channel - one motor channel: phase FSM, phase down-counter, lock, registered outputs.
// Revision: 1.0  (HBRIDGE_BRAKE_EN adds the A=B=1 brake phase after REV)
`default_nettype none

module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEAD_TICKS  = 1,
  parameter int BRAKE_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             rearm,
  input  logic [CNT_W-1:0] fwd_len,
  input  logic [CNT_W-1:0] rev_len,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done
);

`ifdef HBRIDGE_BRAKE_EN
  localparam bit BRAKE_ON = 1'b1;
`else
  localparam bit BRAKE_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DEAD_LEN  = CNT_W'(DEAD_TICKS);
  localparam logic [CNT_W-1:0] BRAKE_LEN = CNT_W'(BRAKE_TICKS);

  phase_e           state, nxt;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] fwd_q, rev_q;
  logic             lock;
  logic             accept, finish;

  // Successor of each phase, skipping zero-length phases within the same tick.
  phase_e           tail_st, rev_st, dead_st, fwd_st;
  logic [CNT_W-1:0] tail_c, rev_c, dead_c, fwd_c;

  always_comb begin
    tail_st = PH_IDLE;
    tail_c  = '0;
    if (BRAKE_ON && (BRAKE_LEN != '0)) begin
      tail_st = PH_BRAKE;
      tail_c  = BRAKE_LEN;
    end
    rev_st  = (rev_q != '0) ? PH_REV : tail_st;
    rev_c   = (rev_q != '0) ? rev_q  : tail_c;
    dead_st = (DEAD_LEN != '0) ? PH_DEAD  : rev_st;
    dead_c  = (DEAD_LEN != '0) ? DEAD_LEN : rev_c;
    fwd_st  = (fwd_q != '0) ? PH_FWD : dead_st;
    fwd_c   = (fwd_q != '0) ? fwd_q  : dead_c;
  end

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    accept  = 1'b0;
    unique case (state)
      PH_IDLE: begin
        if (start && !lock) begin
          accept = 1'b1;
          nxt    = PH_PEND;
        end
      end
      PH_PEND: begin
        if (tick) begin
          nxt     = fwd_st;
          nxt_cnt = fwd_c;
        end
      end
      PH_FWD, PH_DEAD, PH_REV, PH_BRAKE: begin
        if (tick) begin
          if (cnt == CNT_W'(1)) begin
            nxt     = PH_IDLE;
            nxt_cnt = '0;
            if (state == PH_FWD) begin
              nxt     = dead_st;
              nxt_cnt = dead_c;
            end else if (state == PH_DEAD) begin
              nxt     = rev_st;
              nxt_cnt = rev_c;
            end else if (state == PH_REV) begin
              nxt     = tail_st;
              nxt_cnt = tail_c;
            end
          end else begin
            nxt_cnt = cnt - 1'b1;
          end
        end
      end
      default: begin
        nxt     = PH_IDLE;
        nxt_cnt = '0;
      end
    endcase
    finish = (state != PH_IDLE) && (nxt == PH_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PH_IDLE;
      cnt   <= '0;
      fwd_q <= '0;
      rev_q <= '0;
      lock  <= 1'b0;
      a     <= 1'b0;
      b     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      if (accept) begin
        fwd_q <= fwd_len;
        rev_q <= rev_len;
      end
      // rearm takes priority over the lock being set by a completing sequence
      if (rearm) begin
        lock <= 1'b0;
      end else if (finish) begin
        lock <= 1'b1;
      end
      a    <= phase_drives_a(nxt);
      b    <= phase_drives_b(nxt);
      busy <= phase_is_busy(nxt);
      done <= finish;
    end
  end

`ifdef HBRIDGE_BRAKE_EN
  a_brake_only: assert property (@(posedge clk) disable iff (rst)
    (a && b) |-> (state == PH_BRAKE));
`else
  a_no_shoot_through: assert property (@(posedge clk) disable iff (rst) !(a && b));
`endif

endmodule

`default_nettype wire

// File: rtl/hbridge_pulse_seq.sv
// hbridge_pulse_seq - multi-channel H-bridge pulse sequencer: shared tick prescaler plus per-channel FSMs.
// Revision: 1.0  (optional brake phase: define HBRIDGE_BRAKE_EN)
`default_nettype none

module hbridge_pulse_seq
  import hbridge_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int PRESCALE    = 32768,
  parameter int DEAD_TICKS  = 1,
  parameter int BRAKE_TICKS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       rearm,
  input  logic [NUM_CH*CNT_W-1:0] fwd_len,
  input  logic [NUM_CH*CNT_W-1:0] rev_len,
  output logic [NUM_CH-1:0]       A,
  output logic [NUM_CH-1:0]       B,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0] ps_cnt;
  logic            tick;

  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hbridge_channel #(
      .CNT_W      (CNT_W),
      .DEAD_TICKS (DEAD_TICKS),
      .BRAKE_TICKS(BRAKE_TICKS)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .start  (start[i]),
      .rearm  (rearm[i]),
      .fwd_len(fwd_len[i*CNT_W +: CNT_W]),
      .rev_len(rev_len[i*CNT_W +: CNT_W]),
      .a      (A[i]),
      .b      (B[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_hbridge_pulse_seq.sv
// tb_hbridge_pulse_seq - directed self-checking bench for hbridge_pulse_seq (PRESCALE=4, DEAD_TICKS=1).
// Revision: 1.0
`default_nettype none

module tb_hbridge_pulse_seq;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;
`ifdef HBRIDGE_BRAKE_EN
  localparam int EXP_BRK = 8;
`else
  localparam int EXP_BRK = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       start, rearm;
  logic [NUM_CH*CNT_W-1:0] fwd_len, rev_len;
  logic [NUM_CH-1:0]       A, B, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  int r_a[NUM_CH], r_b[NUM_CH], r_ab[NUM_CH], r_gap[NUM_CH], r_lat[NUM_CH];
  int r_fin[NUM_CH], r_busy_done[NUM_CH], r_done_after[NUM_CH];
  int found;

  hbridge_pulse_seq #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PRESCALE   (PRESCALE),
    .DEAD_TICKS (1),
    .BRAKE_TICKS(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rearm  (rearm),
    .fwd_len(fwd_len),
    .rev_len(rev_len),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

`ifndef HBRIDGE_BRAKE_EN
  always @(negedge clk) begin
    if (!rst) check("ab_exclusive", 32'(A & B), 0);
  end
`endif

  task automatic pulse_start(input logic [NUM_CH-1:0] mask);
    @(negedge clk) start = mask;
    @(posedge clk) #1 start = '0;
  endtask

  task automatic pulse_rearm(input logic [NUM_CH-1:0] mask);
    @(negedge clk) rearm = mask;
    @(posedge clk) #1 rearm = '0;
  endtask

  task automatic set_len(input int ch, input int f, input int r);
    fwd_len[ch*CNT_W +: CNT_W] = CNT_W'(f);
    rev_len[ch*CNT_W +: CNT_W] = CNT_W'(r);
  endtask

  // Counts clocks per output pattern from acceptance until the done pulse.
  task automatic observe(input int ch);
    int seen;
    seen = 0;
    r_a[ch] = 0; r_b[ch] = 0; r_ab[ch] = 0; r_gap[ch] = 0; r_lat[ch] = -1;
    r_fin[ch] = 0; r_busy_done[ch] = 1; r_done_after[ch] = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done[ch]) begin
        r_fin[ch]       = 1;
        r_busy_done[ch] = int'(busy[ch]);
        @(negedge clk);
        r_done_after[ch] = int'(done[ch]);
        break;
      end
      if (busy[ch]) begin
        if ((A[ch] || B[ch]) && seen == 0) begin
          seen = 1;
          r_lat[ch] = k;
        end
        if (A[ch] && B[ch]) r_ab[ch]++;
        else if (A[ch])     r_a[ch]++;
        else if (B[ch])     r_b[ch]++;
        else if (seen != 0) r_gap[ch]++;
      end
    end
  endtask

  task automatic verify(input string tag, input int ch, input int ea, input int egap,
                        input int eb, input int lat_lo, input int lat_hi);
    check({tag, "_finished"}, r_fin[ch], 1);
    check({tag, "_a_clks"}, r_a[ch], ea);
    check({tag, "_gap_clks"}, r_gap[ch], egap);
    check({tag, "_b_clks"}, r_b[ch], eb);
    check({tag, "_brake_clks"}, r_ab[ch], EXP_BRK);
    check({tag, "_busy_at_done"}, r_busy_done[ch], 0);
    check({tag, "_done_one_clk"}, r_done_after[ch], 0);
    if (lat_lo >= 0)
      check({tag, "_pend_lat"}, 32'((r_lat[ch] >= lat_lo) && (r_lat[ch] <= lat_hi)), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = '0; rearm = '0; fwd_len = '0; rev_len = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({A, B, busy, done}), 0);
    rst = 1'b0;

    // basic sequence fwd=3 rev=2
    set_len(0, 3, 2);
    pulse_start(2'b01);
    observe(0);
    verify("seq_3_2", 0, 12, 4, 8, 1, 4);

    // locked: start without rearm is ignored
    pulse_start(2'b01);
    repeat (3) @(negedge clk);
    check("locked_start_ignored", 32'(busy[0]), 0);

    pulse_rearm(2'b01);
    pulse_start(2'b01);
    observe(0);
    verify("seq_rearmed", 0, 12, 4, 8, 1, 4);

    // zero forward length skips FWD, dead gap precedes REV
    pulse_rearm(2'b01);
    set_len(0, 0, 2);
    pulse_start(2'b01);
    observe(0);
    verify("seq_0_2", 0, 0, 0, 8, 5, 8);

    pulse_rearm(2'b01);
    set_len(0, 0, 0);
    pulse_start(2'b01);
    observe(0);
    verify("seq_0_0", 0, 0, 0, 0, -1, -1);

    // start with new lengths during FWD must not disturb the running sequence
    pulse_rearm(2'b01);
    set_len(0, 3, 2);
    pulse_start(2'b01);
    fork
      observe(0);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (A[0]) break;
        end
        set_len(0, 7, 5);
        pulse_start(2'b01);
        set_len(0, 3, 2);
      end
    join
    verify("seq_restart_ignored", 0, 12, 4, 8, 1, 4);

    // reset in REV aborts immediately
    pulse_rearm(2'b01);
    pulse_start(2'b01);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (B[0]) begin
        found = 1;
        break;
      end
    end
    check("reached_rev", found, 1);
    rst = 1'b1;
    @(posedge clk) #1;
    check("rst_in_rev_outputs", 32'({A, B, busy, done}), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_rev_idle", 32'({A, B, busy, done}), 0);

    // two channels started together with different lengths
    pulse_rearm(2'b11);
    set_len(0, 2, 1);
    set_len(1, 1, 4);
    pulse_start(2'b11);
    fork
      observe(0);
      observe(1);
    join
    verify("dual_ch0", 0, 8, 4, 4, 1, 4);
    verify("dual_ch1", 1, 4, 4, 16, 1, 4);

    // rearm held through completion beats the lock being set
    pulse_rearm(2'b01);
    set_len(0, 1, 1);
    @(negedge clk) rearm = 2'b01;
    pulse_start(2'b01);
    observe(0);
    check("rearm_hold_finished", r_fin[0], 1);
    rearm = '0;
    pulse_start(2'b01);
    @(negedge clk);
    check("rearm_wins_lock", 32'(busy[0]), 1);
    observe(0);
    check("rearm_wins_seq_done", r_fin[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
